hazard_scoreboard_ctrl: RTL

//  Parametrised decode-stage hazard unit; next generation of the single-stage load-use/pop detector.

---
 rtl/hazard_scoreboard_ctrl.sv | 86 ++++++++
 1 files changed

// File: rtl/hazard_scoreboard_ctrl.sv
// rtl/hazard_scoreboard_ctrl.sv - decode hazard unit with per-register pending-load countdowns.
// Optional HDU_PERF_EN adds a saturating stall-cycle counter on stall_cycles.
module hazard_scoreboard_ctrl #(
  parameter  int RA_W      = 3,
  parameter  int LOAD_LAT  = 1,
  parameter  int JMP_EXTRA = 1,
  localparam int NREG      = 2 ** RA_W,
  localparam int CNT_W     = $clog2(LOAD_LAT + JMP_EXTRA + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_rs_used,
  input  logic            id_rd_used,
  input  logic            id_jmp,
  input  logic            id_mem_read,
  input  logic [RA_W-1:0] id_wr_dst,
  input  logic            flush,
  output logic            stall,
  output logic            bubble,
  output logic [NREG-1:0] pending,
  output logic [15:0]     stall_cycles
);

  localparam logic [CNT_W-1:0] ARM_VAL = CNT_W'(LOAD_LAT + JMP_EXTRA);
  localparam logic [CNT_W-1:0] ALU_THR = CNT_W'(JMP_EXTRA);

  logic [CNT_W-1:0] cnt [NREG];
  logic             rs_haz;
  logic             rd_haz;
  logic             jmp_haz;
  logic             issue;

  // ALU-class operands are ready once only the jump-specific extra slots remain.
  always_comb begin
    rs_haz  = id_rs_used & (cnt[id_rs] > ALU_THR);
    rd_haz  = id_rd_used & (cnt[id_rd] > ALU_THR);
    jmp_haz = id_jmp & id_rd_used & (cnt[id_rd] != '0);
    stall   = id_valid & ~flush & (rs_haz | rd_haz | jmp_haz);
    bubble  = stall;
    issue   = id_valid & ~flush & ~stall & id_mem_read;
  end

  always_comb begin
    pending = '0;
    for (int r = 0; r < NREG; r++) begin
      pending[r] = (cnt[r] != '0);
    end
  end

  // Re-arm beats decrement, so a load to a still-pending register restarts its countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (issue && (id_wr_dst == RA_W'(r))) begin
          cnt[r] <= ARM_VAL;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

`ifdef HDU_PERF_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule
